uart_fifo_tx: RTL and testbench

Transmit serializer directly downstream of the transmit FIFO in the UART datapath. Pops one word at a time through the FIFO's read strobe and drives it onto the serial line. Each frame is one start bit, DATA_WIDTH data bits sent LSB first, an optional even-parity bit and one stop bit. A single bit period is CLKS_PER_BIT clocks.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_fifo_tx.sv | 126 ++++++++++++
 tb/tb_uart_fifo_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state type, line levels and frame length helper.
// Parity support is selected at build time with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Clocks from the start-bit edge to the end of the stop bit.
    function automatic int frame_clocks(input int data_width, input int clks_per_bit,
                                        input bit parity_en);
        return (data_width + (parity_en ? 3 : 2)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, pulses bit_end on the last clock of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;

    assign bit_end = (baud_cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            baud_cnt <= '0;
        end else if (bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmit serializer fed from a FIFO: start bit, LSB-first data, optional even
// parity (UART_TX_PARITY_EN) and one stop bit; frames run back to back while data is queued.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy,
    output tx_state_t             debug_state
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic [IW-1:0]         bit_idx;
    logic                  bit_end;
    logic                  pop_point;
    logic                  restart;
`ifdef UART_TX_PARITY_EN
    logic                  parity;
`endif

    // Handshake: the FIFO presents fifo_data whenever it is not empty; a word is
    // transferred on every rising edge where fifo_read is high, and only then.
    assign pop_point   = (state == IDLE) || ((state == STOP) && bit_end);
    assign fifo_read   = !reset && !fifo_empty && pop_point;
    assign restart     = fifo_read || (state == IDLE);
    assign shreg_next  = shreg >> 1;
    assign debug_state = state;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .restart(restart),
        .bit_end(bit_end)
    );

    // tx and busy are registered from the next-state decision, so they change on the
    // same edge as state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= IDLE_LEVEL;
            busy    <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (fifo_read) begin
            state   <= START;
            tx      <= START_LEVEL;
            busy    <= 1'b1;
            bit_idx <= '0;
            shreg   <= fifo_data;
`ifdef UART_TX_PARITY_EN
            parity  <= ^fifo_data;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx   <= IDLE_LEVEL;
                    busy <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= parity;
`else
                            state   <= STOP;
                            tx      <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg_next;
                            tx      <= shreg_next[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    // A queued word is taken through the fifo_read branch above.
                    if (bit_end) begin
                        state <= IDLE;
                        tx    <= IDLE_LEVEL;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx (DATA_WIDTH=8, CLKS_PER_BIT=4) with a queue-based FIFO model and
// a waveform-level frame scoreboard; honours UART_TX_PARITY_EN.
module tb_uart_fifo_tx;
    import uart_pkg::*;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = DW + 2 + PAR_BITS;
    localparam int LEN   = NBITS * CPB;
    localparam int W     = (DW + 3) * CPB;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_read;
    logic          tx;
    logic          busy;
    tx_state_t     dbg_state;

    logic [DW-1:0] fifo_q[$];
    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clock = ~clock;

    uart_fifo_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .tx         (tx),
        .busy       (busy),
        .debug_state(dbg_state)
    );

    // Expected tx level in every clock of a frame, index 0 = first start-bit clock.
    function automatic logic [W-1:0] frame_of(input logic [DW-1:0] w);
        logic         bits[$];
        logic [W-1:0] v;
        v = '0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
        if (PAR_BITS == 1) bits.push_back(($countones(w) % 2) == 1);
        bits.push_back(1'b1);
        for (int c = 0; c < LEN; c++) v[c] = bits[c / CPB];
        return v;
    endfunction

    function automatic logic [W-1:0] busy_mask();
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < LEN; c++) v[c] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(frame_of(w));
        fifo_refresh();
    endtask

    // Advance n clocks, leaving the bench 2 time units after the last rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1);
            if (busy) seen = 1'b1;
        end
        check("busy_timeout", W'(seen), W'(1));
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            step(1);
            if (fifo_q.size() == 0 && !busy) done = 1'b1;
        end
        check("idle_timeout", W'(done), W'(1));
        step(2);
    endtask

    // FIFO model: a word leaves on the edge that follows a cycle with fifo_read high.
    bit pop_now;
    always begin
        @(negedge clock);
        pop_now = fifo_read;
        @(posedge clock);
        #1;
        if (pop_now) begin
            if (fifo_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fifo_underflow t=%0t actual=pop required=no_pop", $time);
            end else begin
                void'(fifo_q.pop_front());
            end
            fifo_refresh();
        end
    end

    // Monitor: samples on the falling edge and scores whole frames against exp_q.
    bit           in_frame = 1'b0;
    bit           rst_d    = 1'b0;
    int           k        = 0;
    logic [W-1:0] act_tx;
    logic [W-1:0] act_busy;
    logic [W-1:0] exp_frame;

    always @(negedge clock) begin
        logic exp_pop;
        if (rst_d) begin
            check("reset_out", W'({tx, busy}), W'(2'b10));
            in_frame = 1'b0;
            k        = 0;
        end
        if (!reset && !in_frame && busy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_expected t=%0t actual=frame required=no_frame", $time);
            end else begin
                exp_frame = exp_q.pop_front();
                in_frame  = 1'b1;
                k         = 0;
                act_tx    = '0;
                act_busy  = '0;
            end
        end
        exp_pop = !reset && !fifo_empty && (!in_frame || k == LEN - 1);
        check("pop_strobe", W'(fifo_read), W'(exp_pop));
        if (!reset) begin
            if (in_frame) begin
                act_tx[k]   = tx;
                act_busy[k] = busy;
                k++;
                if (k == LEN) begin
                    check("frame_tx", act_tx, exp_frame);
                    check("frame_busy", act_busy, busy_mask());
                    in_frame = 1'b0;
                    k        = 0;
                end
            end else begin
                check("idle_line", W'({tx, busy}), W'(2'b10));
            end
        end
        rst_d = reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fifo_refresh();
        step(3);
        reset = 1'b0;
        step(20);

        write_word(8'hA5);
        wait_idle();

        write_word(8'h00);
        write_word(8'hFF);
        wait_idle();

        write_word(8'h01);
        write_word(8'h03);
        wait_idle();

        // Abort 0x5A during data bit 3 (frame clocks 16..19) with 0x3C still queued.
        write_word(8'h5A);
        write_word(8'h3C);
        wait_busy();
        step(17);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        wait_idle();

        step(100);
        write_word(DW'($urandom_range(0, 255)));
        wait_idle();

        for (int i = 0; i < 25; i++) begin
            write_word(DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) write_word(DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) step($urandom_range(0, 60));
        end
        wait_idle();

        check("exp_queue_drained", W'(exp_q.size()), '0);
        check("fifo_drained", W'(fifo_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
